quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4, sets the consecutive synchronized cycles (2..255) a channel level holds before acceptance.
REQ-002 Parameter CNT_W, default 16, sets the position counter width in bits.
REQ-003 cclk  input  1  single clock; all logic is on the rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 a  input  1  raw encoder channel A, asynchronous to cclk.
REQ-006 b  input  1  raw encoder channel B, asynchronous to cclk.
REQ-007 clr  input  1  synchronous clear of pos.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 a_f  output  1  filtered channel A, feeding the downstream RPM stage.
REQ-010 b_f  output  1  filtered channel B, feeding the downstream RPM stage.
REQ-011 pos  output  CNT_W  signed two's-complement position count.
REQ-012 step  output  1  one-cycle pulse per legal quadrature transition.
REQ-013 dir  output  1  direction of the last legal step: 1 = forward, 0 = reverse.
REQ-014 err  output  1  sticky flag for an illegal (double-bit) transition.
REQ-015 valid  output  1  high once the initial input state has been captured.

Function
REQ-016 Each channel SHALL pass through a 2-flop synchronizer before any other logic.
REQ-017 Each channel SHALL have an independent filter counter, as follows.
- Increment while the synchronized value differs from the filtered value.
- Reset to 0 on any cycle where they match.
- Toggle the filtered bit on the edge where the counter would reach FILTER_LEN.
REQ-018 Mismatches shorter than FILTER_LEN synchronized cycles SHALL leave a_f/b_f, pos, step and err unchanged.
REQ-019 The block SHALL implement a two-state FSM, INIT and RUN, with INIT entered on reset.
REQ-020 INIT behaviour:
- Per-channel stability counters run.
- When both channels have been stable for FILTER_LEN cycles, load a_f/b_f directly from the synchronizers.
- Set valid=1 and go to RUN.
- Never assert step or err in INIT.
REQ-021 RUN behaviour: compare {a_f,b_f} against its value on the previous cycle every cycle.
REQ-022 Forward sequence is 00->10->11->01->00 (A leads B): pos+1, dir=1, step=1 for one cycle.
REQ-023 Reverse sequence is 00->01->11->10->00: pos-1, dir=0, step=1 for one cycle.
REQ-024 Both bits changing in one cycle SHALL set err=1, leave pos and dir unchanged, and keep step=0.
REQ-025 Latency: a clean pin level change held steady produces step and the pos update after the (FILTER_LEN+3)th rising edge sampling it.
REQ-026 pos SHALL wrap modulo 2^CNT_W in both directions: max+1 gives min, min-1 gives max.
REQ-027 clr SHALL set pos=0 on the next edge.
REQ-028 clr coincident with a step SHALL give pos=0, but step and dir still update.
REQ-029 err_clr SHALL clear err on the next edge.
REQ-030 err_clr coincident with an illegal transition SHALL leave err=1 (set wins).
REQ-031 clr and err_clr SHALL have no effect on the FSM or the filters.

Reset
REQ-032 While rstb=0, all of the following SHALL be 0:
- synchronizer flops and filter counters
- a_f, b_f, pos, step, dir, err, valid
- the FSM, held in INIT.
REQ-033 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge.
REQ-034 After release, the block SHALL re-enter INIT, so the input state at release never counts as a transition.

Verification
REQ-035 The bench SHALL cover these directed scenarios (FILTER_LEN=4, CNT_W=16):
- Reset release with a=1,b=1 held: valid=1 and a_f=b_f=1 after 6 edges; pos=0, err=0, no step.
- From 00 in RUN, four forward transitions each held 10 cycles: four single-cycle step pulses, pos=4, dir=1; each step occurs 7 edges after its pin change.
- 3-cycle glitch on a: no a_f change, no step, pos unchanged. 4-cycle pulse on a: a_f toggles.
- a and b toggled in the same cycle in RUN: err=1, pos and dir unchanged. err_clr asserted in the same cycle as a second illegal transition: err stays 1.
- pos driven to 0x7FFF, then one forward step: pos=0x8000. From 0x0000, one reverse step: pos=0xFFFF.
- clr coincident with a forward step: pos=0, step=1, dir=1. rstb pulsed low mid-sequence: all outputs 0 immediately, and the INIT sequence repeats.

Source files
------------

// File: rtl/quad_decoder_if.sv
// Signal bundle between a quadrature decoder and whatever drives/consumes it.
// The master drives the raw encoder pins and clears; the slave is the decoder.
interface quad_decoder_if #(
  parameter int CNT_W = 16
);
  logic             a;
  logic             b;
  logic             clr;
  logic             err_clr;
  logic             a_f;
  logic             b_f;
  logic [CNT_W-1:0] pos;
  logic             step;
  logic             dir;
  logic             err;
  logic             valid;

  modport master (
    output a, b, clr, err_clr,
    input  a_f, b_f, pos, step, dir, err, valid
  );

  modport slave (
    input  a, b, clr, err_clr,
    output a_f, b_f, pos, step, dir, err, valid
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: per-channel synchronizer and glitch filter,
// INIT/RUN state machine, signed wrapping position counter and sticky error flag.
module quad_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 16
) (
  input  logic          cclk,
  input  logic          rstb,
  quad_decoder_if.slave bus
);

  localparam logic [0:0] INIT      = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [1:0]       syncA_q, syncB_q;
  logic [7:0]       cntA_q, cntA_d, cntB_q, cntB_d;
  logic             aF_q, aF_d, bF_q, bF_d;
  logic [0:0]       state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic       sA, sB, stableA, stableB, inRun;
  logic [1:0] delta;
  logic       fwd, rev, illegal;

  // Gray phase of {a,b}: 00->0, 10->1, 11->2, 01->3, so forward is +1 mod 4.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  assign sA      = syncA_q[1];
  assign sB      = syncB_q[1];
  assign stableA = (syncA_q[0] == syncA_q[1]);
  assign stableB = (syncB_q[0] == syncB_q[1]);
  assign inRun   = (state_q == RUN);
  assign delta   = phase({aF_q, bF_q}) - phase(prev_q);
  assign fwd     = inRun && (delta == 2'd1);
  assign rev     = inRun && (delta == 2'd3);
  assign illegal = inRun && (delta == 2'd2);

  always_comb begin
    cntA_d  = cntA_q;
    cntB_d  = cntB_q;
    aF_d    = aF_q;
    bF_d    = bF_q;
    state_d = state_q;
    prev_d  = prev_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    err_d   = bus.err_clr ? 1'b0 : err_q;

    case (state_q)
      INIT: begin
        // Counters measure how long each synchronized pin has held still.
        cntA_d = stableA ? ((cntA_q == FILT_LAST) ? cntA_q : cntA_q + 8'd1) : 8'd0;
        cntB_d = stableB ? ((cntB_q == FILT_LAST) ? cntB_q : cntB_q + 8'd1) : 8'd0;
        if (stableA && stableB && (cntA_q == FILT_LAST) && (cntB_q == FILT_LAST)) begin
          aF_d    = sA;
          bF_d    = sB;
          prev_d  = {sA, sB};
          valid_d = 1'b1;
          cntA_d  = 8'd0;
          cntB_d  = 8'd0;
          state_d = RUN;
        end
      end
      default: begin
        if (sA != aF_q) begin
          if (cntA_q == FILT_LAST) begin
            aF_d   = ~aF_q;
            cntA_d = 8'd0;
          end else begin
            cntA_d = cntA_q + 8'd1;
          end
        end else begin
          cntA_d = 8'd0;
        end
        if (sB != bF_q) begin
          if (cntB_q == FILT_LAST) begin
            bF_d   = ~bF_q;
            cntB_d = 8'd0;
          end else begin
            cntB_d = cntB_q + 8'd1;
          end
        end else begin
          cntB_d = 8'd0;
        end
        prev_d = {aF_q, bF_q};
        if (fwd) begin
          pos_d  = pos_q + 1'b1;
          dir_d  = 1'b1;
          step_d = 1'b1;
        end else if (rev) begin
          pos_d  = pos_q - 1'b1;
          dir_d  = 1'b0;
          step_d = 1'b1;
        end else if (illegal) begin
          err_d = 1'b1;
        end
      end
    endcase

    // Clear overrides the count but the step and direction still report.
    if (bus.clr) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      syncA_q <= '0;
      syncB_q <= '0;
      cntA_q  <= '0;
      cntB_q  <= '0;
      aF_q    <= 1'b0;
      bF_q    <= 1'b0;
      state_q <= INIT;
      prev_q  <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      syncA_q <= {syncA_q[0], bus.a};
      syncB_q <= {syncB_q[0], bus.b};
      cntA_q  <= cntA_d;
      cntB_q  <= cntB_d;
      aF_q    <= aF_d;
      bF_q    <= bF_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a_f   = aF_q;
  assign bus.b_f   = bF_q;
  assign bus.pos   = pos_q;
  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.err   = err_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with FILTER_LEN=4, CNT_W=16: a pin change
// held steady shows up as a step 7 edges later.
module tb_quad_decoder;

  logic cclk;
  logic rstb;
  int   passCount;
  int   checkCount;
  int   failCount;
  logic seen;

  quad_decoder_if #(.CNT_W(16)) bus ();

  quad_decoder #(.FILTER_LEN(4), .CNT_W(16)) dut (
    .cclk (cclk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic tick(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic applyStimulus(input logic na, input logic nb);
    bus.a = na;
    bus.b = nb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a new pin pair and expect exactly one step pulse on the 7th edge.
  task automatic expectStep(input string tag, input logic na, input logic nb,
                            input logic [15:0] expPos, input logic expDir);
    applyStimulus(na, nb);
    tick(6);
    checkOutput({tag, "_early"}, 32'(bus.step), 32'd0);
    tick(1);
    checkOutput({tag, "_step"}, 32'(bus.step), 32'd1);
    checkOutput({tag, "_pos"}, 32'(bus.pos), 32'(expPos));
    checkOutput({tag, "_dir"}, 32'(bus.dir), 32'(expDir));
    tick(1);
    checkOutput({tag, "_pulse"}, 32'(bus.step), 32'd0);
    tick(2);
  endtask

  initial begin
    passCount   = 0;
    checkCount  = 0;
    failCount   = 0;
    rstb        = 1'b0;
    bus.clr     = 1'b0;
    bus.err_clr = 1'b0;
    applyStimulus(1'b1, 1'b1);

    // Reset state, then release with 11 held: valid on the 6th edge.
    tick(3);
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_af", 32'(bus.a_f), 32'd0);
    checkOutput("rst_pos", 32'(bus.pos), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_step", 32'(bus.step), 32'd0);
    rstb = 1'b1;
    tick(5);
    checkOutput("init_valid_early", 32'(bus.valid), 32'd0);
    tick(1);
    checkOutput("init_valid", 32'(bus.valid), 32'd1);
    checkOutput("init_af", 32'(bus.a_f), 32'd1);
    checkOutput("init_bf", 32'(bus.b_f), 32'd1);
    checkOutput("init_pos", 32'(bus.pos), 32'd0);
    checkOutput("init_err", 32'(bus.err), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.step) seen = 1'b1;
      tick(1);
    end
    checkOutput("init_nostep", 32'(seen), 32'd0);

    // Re-enter INIT from 00.
    rstb = 1'b0;
    #1;
    applyStimulus(1'b0, 1'b0);
    tick(2);
    rstb = 1'b1;
    tick(8);
    checkOutput("init00_valid", 32'(bus.valid), 32'd1);
    checkOutput("init00_pos", 32'(bus.pos), 32'd0);

    // Four forward transitions.
    expectStep("fwd1", 1'b1, 1'b0, 16'd1, 1'b1);
    expectStep("fwd2", 1'b1, 1'b1, 16'd2, 1'b1);
    expectStep("fwd3", 1'b0, 1'b1, 16'd3, 1'b1);
    expectStep("fwd4", 1'b0, 1'b0, 16'd4, 1'b1);

    // 3-cycle glitch is rejected.
    applyStimulus(1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.a_f || bus.step) seen = 1'b1;
    end
    checkOutput("glitch_quiet", 32'(seen), 32'd0);
    checkOutput("glitch_pos", 32'(bus.pos), 32'd4);

    // 4-cycle pulse passes: forward then reverse step.
    applyStimulus(1'b1, 1'b0);
    tick(4);
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkOutput("pulse_af", 32'(bus.a_f), 32'd1);
    tick(1);
    checkOutput("pulse_step_fwd", 32'(bus.step), 32'd1);
    checkOutput("pulse_pos_fwd", 32'(bus.pos), 32'd5);
    tick(4);
    checkOutput("pulse_step_rev", 32'(bus.step), 32'd1);
    checkOutput("pulse_pos_rev", 32'(bus.pos), 32'd4);
    checkOutput("pulse_dir_rev", 32'(bus.dir), 32'd0);
    tick(3);

    // Illegal double-bit change, then err_clr racing a second one.
    applyStimulus(1'b1, 1'b1);
    tick(7);
    checkOutput("ill_err", 32'(bus.err), 32'd1);
    checkOutput("ill_step", 32'(bus.step), 32'd0);
    checkOutput("ill_pos", 32'(bus.pos), 32'd4);
    checkOutput("ill_dir", 32'(bus.dir), 32'd0);
    tick(3);
    applyStimulus(1'b0, 1'b0);
    tick(6);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    checkOutput("ill2_setwins", 32'(bus.err), 32'd1);
    checkOutput("ill2_pos", 32'(bus.pos), 32'd4);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    checkOutput("errclr", 32'(bus.err), 32'd0);

    // Wrap in both directions.
    force dut.pos_q = 16'h7FFF;
    tick(1);
    release dut.pos_q;
    checkOutput("preset_pos", 32'(bus.pos), 32'h7FFF);
    expectStep("wrap_fwd", 1'b1, 1'b0, 16'h8000, 1'b1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checkOutput("clr_pos", 32'(bus.pos), 32'd0);
    expectStep("wrap_rev", 1'b0, 1'b0, 16'hFFFF, 1'b0);

    // clr coincident with a forward step.
    applyStimulus(1'b1, 1'b0);
    tick(6);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checkOutput("clrstep_pos", 32'(bus.pos), 32'd0);
    checkOutput("clrstep_step", 32'(bus.step), 32'd1);
    checkOutput("clrstep_dir", 32'(bus.dir), 32'd1);
    tick(3);

    // Asynchronous reset mid-operation, then INIT repeats.
    expectStep("prereset", 1'b1, 1'b1, 16'd1, 1'b1);
    #2;
    rstb = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.valid), 32'd0);
    checkOutput("midrst_af", 32'(bus.a_f), 32'd0);
    checkOutput("midrst_bf", 32'(bus.b_f), 32'd0);
    checkOutput("midrst_pos", 32'(bus.pos), 32'd0);
    checkOutput("midrst_dir", 32'(bus.dir), 32'd0);
    @(posedge cclk);
    #1;
    rstb = 1'b1;
    tick(5);
    checkOutput("reinit_valid_early", 32'(bus.valid), 32'd0);
    tick(1);
    checkOutput("reinit_valid", 32'(bus.valid), 32'd1);
    checkOutput("reinit_af", 32'(bus.a_f), 32'd1);
    checkOutput("reinit_bf", 32'(bus.b_f), 32'd1);
    tick(2);
    checkOutput("reinit_step", 32'(bus.step), 32'd0);
    checkOutput("reinit_pos", 32'(bus.pos), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
